// File: rtl/pe_pkg.sv
// Shared types and defaults for the systolic processing element (pe_mac).
// No logic; the saturating build is selected with PE_MAC_SAT_EN in pe_mac_sat.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_LOAD = 2'd1,
    PE_WS   = 2'd2,
    PE_OS   = 2'd3
  } pe_mode_t;

  localparam int PE_DW = 8;
  localparam int PE_AW = 20;

endpackage

// File: rtl/pe_mac_sat.sv
// Signed AW-bit adder with overflow detect; clamps when PE_MAC_SAT_EN is defined, wraps otherwise.
// Combinational, zero latency; no flow control.
module pe_mac_sat #(
  parameter int AW = 20
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 ovf
);

  logic signed [AW-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign and the result does not.
  assign ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);

`ifdef PE_MAC_SAT_EN
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/pe_mac.sv
// Weight-/output-stationary MAC processing element; outputs registered, 1-cycle latency.
// valid-only (no backpressure); optional clamping via PE_MAC_SAT_EN in pe_mac_sat.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DW = PE_DW,
  parameter int AW = PE_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] act_i,
  input  logic signed [DW-1:0] wgt_i,
  input  logic signed [AW-1:0] psum_i,
  input  logic                 swap_i,
  output logic signed [DW-1:0] act_o,
  output logic                 valid_o,
  output logic [1:0]           mode_o,
  output logic signed [AW-1:0] psum_o,
  output logic                 ovf_o
);

  localparam int PW = 2 * DW;

  if (AW < 2 * DW) begin : g_bad_aw
    $error("pe_mac: AW must be at least 2*DW");
  end

  pe_mode_t             state;
  pe_mode_t             mode_in;
  logic signed [DW-1:0] shadow_w;
  logic signed [DW-1:0] active_w;
  logic signed [DW-1:0] mul_b;
  logic signed [PW-1:0] act_x;
  logic signed [PW-1:0] mul_x;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] add_a;
  logic signed [AW-1:0] add_b;
  logic signed [AW-1:0] add_sum;
  logic                 add_ovf;
  logic                 is_os;
  logic                 is_ws;
  logic                 restart;

  assign mode_in = pe_mode_t'(mode_i);
  assign is_ws   = valid_i && (mode_in == PE_WS);
  assign is_os   = valid_i && (mode_in == PE_OS);
  // Any accepted OS beat arriving from a non-OS state starts a fresh accumulation.
  assign restart = (state != PE_OS);

  // One multiplier serves both datapaths: streamed weight in OS, stationary weight otherwise.
  assign mul_b = (mode_in == PE_OS) ? wgt_i : active_w;
  assign act_x = PW'(act_i);
  assign mul_x = PW'(mul_b);
  assign prod  = act_x * mul_x;

  assign add_a = (mode_in == PE_OS) ? (restart ? '0 : acc) : psum_i;
  assign add_b = AW'(prod);

  pe_mac_sat #(.AW(AW)) u_sat (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PE_IDLE;
      act_o    <= '0;
      valid_o  <= 1'b0;
      mode_o   <= PE_IDLE;
      psum_o   <= '0;
      acc      <= '0;
      shadow_w <= '0;
      active_w <= '0;
      ovf_o    <= 1'b0;
    end else begin
      act_o   <= act_i;
      valid_o <= valid_i;
      mode_o  <= mode_i;
      if (valid_i) begin
        state <= mode_in;
        case (mode_in)
          PE_LOAD: shadow_w <= wgt_i;
          PE_WS:   psum_o   <= add_sum;
          PE_OS: begin
            acc    <= add_sum;
            psum_o <= add_sum;
          end
          default: ;
        endcase
        // Swap reads the pre-edge shadow, so a same-cycle LOAD commits the older weight.
        if (swap_i && (mode_in != PE_IDLE)) begin
          active_w <= shadow_w;
        end
        if ((is_ws || is_os) && add_ovf) begin
          ovf_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pe_mac.md
PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 Parameter DW, default 8: signed two's-complement width of activation and weight.
REQ-002 Parameter AW, default 20: signed partial-sum/accumulator width; AW SHALL be >= 2*DW.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode_i  input  2  operating mode, pe_mode_t encoding: IDLE=0, LOAD=1, WS=2, OS=3.
REQ-006 valid_i  input  1  act_i/psum_i/wgt_i qualified this cycle.
REQ-007 act_i  input  DW  activation from west neighbour.
REQ-008 wgt_i  input  DW  weight: shadow load in LOAD, streamed operand in OS.
REQ-009 psum_i  input  AW  partial sum from north neighbour (WS).
REQ-010 swap_i  input  1  commit shadow weight to active weight.
REQ-011 act_o  output  DW  registered act_i to east neighbour.
REQ-012 valid_o  output  1  registered valid_i.
REQ-013 mode_o  output  2  registered mode_i.
REQ-014 psum_o  output  AW  result to south neighbour.
REQ-015 ovf_o  output  1  sticky overflow flag.

Function
REQ-016 act_o, valid_o, mode_o SHALL equal act_i, valid_i, mode_i delayed exactly one cycle, in every mode.
REQ-017 The FSM SHALL hold state IDLE/LOAD/WS/OS; state is updated to mode_i on each cycle with valid_i=1 and held when valid_i=0.
REQ-018 LOAD, valid_i=1: shadow_w <= wgt_i; psum_o holds its value.
REQ-019 swap_i=1 in any mode: active_w <= shadow_w; with a simultaneous LOAD, active_w takes the old shadow_w and shadow_w takes wgt_i.
REQ-020 WS, valid_i=1: psum_o <= psum_i + act_i*active_w (signed, product sign-extended to AW); latency 1 cycle, aligned with valid_o.
REQ-021 OS, valid_i=1: acc <= acc + act_i*wgt_i; psum_o SHALL present acc (registered, 1-cycle latency).
REQ-022 Entering OS from any other state SHALL restart acc: the first accepted OS beat sets acc = act_i*wgt_i.
REQ-023 IDLE, or valid_i=0: acc, psum_o, and both weights SHALL hold; no arithmetic is committed.
REQ-024 Overflow: an adder result outside the signed AW range SHALL set ovf_o, which remains set until reset.
REQ-025 Mode changes take effect on the same cycle valid_i=1 is presented, with no bubble.

Reset
REQ-026 rst=1 SHALL asynchronously clear act_o, psum_o, acc, shadow_w, active_w, and ovf_o to 0.
REQ-027 rst=1 SHALL asynchronously clear valid_o to 0, set mode_o to IDLE, and set the FSM to IDLE.
REQ-028 A reset asserted mid-accumulation discards acc; the first OS beat after reset follows REQ-022.

Configuration
REQ-029 Macro PE_MAC_SAT_EN defined: out-of-range WS/OS results SHALL clamp to +(2^(AW-1)-1) or -2^(AW-1).
REQ-030 Macro PE_MAC_SAT_EN undefined: results SHALL wrap modulo 2^AW; ovf_o behaviour is identical in both builds.

Structure
REQ-031 Package pe_pkg SHALL hold pe_mode_t, the mode constants, and the default DW/AW localparams.
REQ-032 A single sub-module, pe_mac_sat (signed add with overflow detect and optional clamp), SHALL be shared by the WS and OS paths; the multiplier is inferred.

Verification (DW=8, AW=20)
REQ-033 LOAD wgt=3, swap, then WS act=5 psum_i=10 -> next cycle psum_o=25, valid_o=1, act_o=5.
REQ-034 WS act=-128 with active_w=-128, psum_i=0 -> psum_o=16384; act=-1 with w=127, psum_i=0 -> psum_o=-127.
REQ-035 OS 4 beats act=2 wgt=3, with a valid_i=0 gap after beat 2 -> psum_o=6,12,12,18,24; re-entering OS from WS with act=1 wgt=1 -> psum_o=1.
REQ-036 WS psum_i=524000, act=127, w=127 -> with PE_MAC_SAT_EN psum_o=524287; without it psum_o=-508447; ovf_o=1 in both builds.
REQ-037 LOAD wgt=9 with swap_i in the same cycle while shadow=4 -> active_w=4; a second swap -> active_w=9.
REQ-038 rst pulsed between OS beats after acc=18 -> psum_o=0, mode_o=IDLE, ovf_o=0; the next OS beat act=2 wgt=3 -> psum_o=6.
